// File: rtl/agri_soc_pkg.sv
// Shared types and default sizing for the sensor scan scheduler.
package agri_soc_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int DATA_W_DEF = 12;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        REQ,
        WAIT,
        STORE
    } scan_state_t;

endpackage

// File: rtl/scan_tick_timer.sv
// Free-running period timer that emits a one-cycle tick every PERIOD cycles while enabled.
// Latency: tick is combinational on the terminal count, so it coincides with count PERIOD-1.
// Backpressure: none; the count is held at zero whenever enable is low.
module scan_tick_timer #(
    parameter int PERIOD = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [W-1:0] cnt;

    assign tick = enable && (cnt == W'(PERIOD - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/sensor_scan_scheduler.sv
// Scans the masked sensor channels through one shared ADC once per PERIOD and raises per-channel threshold alarms.
// Latency: sample_valid pulses exactly one cycle after the accepted adc_valid.
// Backpressure: none downstream; ADC waits are bounded by TIMEOUT and ticks arriving mid-scan are dropped and flagged.
module sensor_scan_scheduler
    import agri_soc_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PERIOD  = 1000,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         ch_mask,
    input  logic [DATA_W-1:0]         thresh,
    output logic                      adc_req,
    output logic [$clog2(NUM_CH)-1:0] adc_ch,
    input  logic                      adc_valid,
    input  logic [DATA_W-1:0]         adc_data,
    output logic                      sample_valid,
    output logic [$clog2(NUM_CH)-1:0] sample_ch,
    output logic [DATA_W-1:0]         sample_data,
    output logic [NUM_CH-1:0]         LED,
    output logic                      scan_done,
    output logic                      timeout_err,
    output logic                      overrun_err
);

    localparam int CW = $clog2(NUM_CH);
    // One spare pointer bit so "past the last channel" is representable and ends the scan.
    localparam int PW = CW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    scan_state_t       state;
    scan_state_t       state_d;
    logic              tick;
    logic [NUM_CH-1:0] mask_q;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     nxt_ptr;
    logic [TW-1:0]     wcnt;
    logic              found;
    logic              scan_start;
    logic              sel_go;
    logic              done_set;
    logic              capture;
    logic              tmo;
    logic              store;

    scan_tick_timer #(
        .PERIOD(PERIOD)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .tick  (tick)
    );

    // Lowest latched-enabled channel at or above the pointer.
    always_comb begin
        found   = 1'b0;
        nxt_ptr = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (PW'(i) >= ptr)) begin
                found   = 1'b1;
                nxt_ptr = PW'(i);
            end
        end
    end

    always_comb begin
        state_d    = state;
        scan_start = 1'b0;
        sel_go     = 1'b0;
        done_set   = 1'b0;
        capture    = 1'b0;
        tmo        = 1'b0;
        store      = 1'b0;
        case (state)
            IDLE: begin
                if (tick && enable && (|ch_mask)) begin
                    scan_start = 1'b1;
                    state_d    = SELECT;
                end
            end
            SELECT: begin
                // A disabled scheduler abandons the scan silently once the in-flight sample is out.
                if (!enable) begin
                    state_d = IDLE;
                end else if (found) begin
                    sel_go  = 1'b1;
                    state_d = REQ;
                end else begin
                    done_set = 1'b1;
                    state_d  = IDLE;
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (adc_valid) begin
                    capture = 1'b1;
                    state_d = STORE;
                end else if (wcnt == TW'(TIMEOUT - 1)) begin
                    tmo     = 1'b1;
                    state_d = SELECT;
                end
            end
            STORE: begin
                store   = 1'b1;
                state_d = SELECT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q      <= '0;
            ptr         <= '0;
            wcnt        <= '0;
            sample_ch   <= '0;
            sample_data <= '0;
            LED         <= '0;
            scan_done   <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            scan_done <= done_set;
            if (scan_start) begin
                mask_q <= ch_mask;
                ptr    <= '0;
            end
            if (sel_go) begin
                ptr <= nxt_ptr;
            end
            if (tmo || store) begin
                ptr <= ptr + PW'(1);
            end
            if (state == WAIT) begin
                wcnt <= wcnt + TW'(1);
            end else begin
                wcnt <= '0;
            end
            if (capture) begin
                sample_data <= adc_data;
                sample_ch   <= ptr[CW-1:0];
            end
            if (store) begin
                LED[ptr[CW-1:0]] <= (sample_data > thresh);
            end
            if (tmo) begin
                timeout_err <= 1'b1;
            end
            if (tick && (state != IDLE)) begin
                overrun_err <= 1'b1;
            end
        end
    end

    // Request and publish strobes decode straight from state so reset drops them immediately.
    assign adc_req      = (state == REQ) || (state == WAIT);
    assign adc_ch       = ptr[CW-1:0];
    assign sample_valid = (state == STORE);

endmodule

// File: tb/tb_sensor_scan_scheduler.sv
// Scoreboard bench: directed scans against a behavioural ADC, monitor compares published samples.
module tb_sensor_scan_scheduler;
    import agri_soc_pkg::*;

    typedef struct {
        int ch;
        int data;
    } smp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  ch_mask;
    logic [11:0] thresh;
    logic        adc_req;
    logic [1:0]  adc_ch;
    logic        adc_valid;
    logic [11:0] adc_data;
    logic        sample_valid;
    logic [1:0]  sample_ch;
    logic [11:0] sample_data;
    logic [3:0]  LED;
    logic        scan_done;
    logic        timeout_err;
    logic        overrun_err;

    logic        en2;
    logic        req2;
    logic [1:0]  ch2;
    logic        valid2;
    logic [11:0] data2;
    logic        sv2;
    logic [1:0]  sch2;
    logic [11:0] sdat2;
    logic [3:0]  led2;
    logic        done2;
    logic        tmo2;
    logic        ovr2;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   vld_cyc = 0;
    int   done_cnt = 0;
    int   done2_cnt = 0;
    int   ns2 = 0;
    int   adc_lat = 3;
    int   silent_ch = -1;
    int   adc_vals[4];
    int   inj_cnt = 0;
    int   inj_seen = 0;
    logic [11:0] inj_data = '0;
    int   hold = 0;
    int   h2 = 0;
    int   req_log[$];
    int   hold_log[$];
    smp_t exp_q[$];
    smp_t exp2_q[$];

    sensor_scan_scheduler #(
        .NUM_CH(4), .DATA_W(12), .PERIOD(50), .TIMEOUT(8)
    ) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask), .thresh(thresh),
        .adc_req(adc_req), .adc_ch(adc_ch), .adc_valid(adc_valid), .adc_data(adc_data),
        .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
        .LED(LED), .scan_done(scan_done), .timeout_err(timeout_err), .overrun_err(overrun_err)
    );

    // Longer timeout so a 20-cycle ADC can stretch a scan past one period.
    sensor_scan_scheduler #(
        .NUM_CH(4), .DATA_W(12), .PERIOD(50), .TIMEOUT(32)
    ) u_ovr (
        .clk(clk), .reset(reset), .enable(en2), .ch_mask(4'hF), .thresh(12'd100),
        .adc_req(req2), .adc_ch(ch2), .adc_valid(valid2), .adc_data(data2),
        .sample_valid(sv2), .sample_ch(sch2), .sample_data(sdat2),
        .LED(led2), .scan_done(done2), .timeout_err(tmo2), .overrun_err(ovr2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req_ch(input int ch);
        int n = 0;
        while (!(adc_req && int'(adc_ch) == ch) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("wait_req_ch%0d", ch), n < 200, 1);
    endtask

    // Behavioural ADC for the main instance, plus a one-shot stray-pulse injector.
    initial begin
        adc_valid = 1'b0;
        adc_data  = '0;
        forever begin
            @(negedge clk);
            adc_valid = 1'b0;
            if (inj_cnt != inj_seen) begin
                inj_seen  = inj_cnt;
                adc_valid = 1'b1;
                adc_data  = inj_data;
            end else if (adc_req) begin
                hold++;
                if (hold == 1) req_log.push_back(int'(adc_ch));
                if (hold == adc_lat && int'(adc_ch) != silent_ch) begin
                    adc_valid = 1'b1;
                    adc_data  = 12'(adc_vals[adc_ch]);
                    vld_cyc   = cyc;
                end
            end else if (hold != 0) begin
                hold_log.push_back(hold);
                hold = 0;
            end
        end
    end

    initial begin
        valid2 = 1'b0;
        data2  = '0;
        forever begin
            @(negedge clk);
            valid2 = 1'b0;
            if (req2) begin
                h2++;
                if (h2 == 20) begin
                    valid2 = 1'b1;
                    data2  = 12'(200 + int'(ch2));
                end
            end else begin
                h2 = 0;
            end
        end
    end

    initial begin
        smp_t e;
        forever begin
            @(negedge clk);
            if (sample_valid) begin
                chk("latency_valid_to_sample", cyc - vld_cyc, 1);
                chk("sample_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sample_ch", sample_ch, e.ch);
                    chk("sample_data", sample_data, e.data);
                end
            end
            if (sv2) begin
                ns2++;
                chk("ovr_sample_expected", exp2_q.size() > 0, 1);
                if (exp2_q.size() > 0) begin
                    e = exp2_q.pop_front();
                    chk("ovr_sample_ch", sch2, e.ch);
                    chk("ovr_sample_data", sdat2, e.data);
                end
            end
            if (scan_done) done_cnt++;
            if (done2) done2_cnt++;
        end
    end

    initial begin
        int d0;
        int r0;
        int h0;
        reset = 1'b0; enable = 1'b0; en2 = 1'b0; ch_mask = '0; thresh = '0;
        cycles(3);
        chk("rst_adc_req", adc_req, 0);
        chk("rst_sample_valid", sample_valid, 0);
        chk("rst_scan_done", scan_done, 0);
        chk("rst_led", LED, 0);
        chk("rst_adc_ch", adc_ch, 0);
        chk("rst_sample_data", sample_data, 0);
        chk("rst_errors", {timeout_err, overrun_err, tmo2, ovr2}, 0);
        reset = 1'b1;
        cycles(2);

        // Full scan, 3-cycle ADC.
        thresh = 12'd100; ch_mask = 4'b1111; adc_lat = 3;
        adc_vals = '{50, 150, 99, 101};
        exp_q.push_back('{0, 50}); exp_q.push_back('{1, 150});
        exp_q.push_back('{2, 99}); exp_q.push_back('{3, 101});
        d0 = done_cnt; r0 = req_log.size();
        enable = 1'b1; cycles(80); enable = 1'b0; cycles(2);
        chk("full_led", LED, 4'b1010);
        chk("full_scan_done", done_cnt - d0, 1);
        chk("full_queue_drained", exp_q.size(), 0);
        chk("full_nreq", req_log.size() - r0, 4);

        // Masked scan.
        ch_mask = 4'b0101; adc_vals[0] = 200; adc_vals[2] = 5;
        exp_q.push_back('{0, 200}); exp_q.push_back('{2, 5});
        d0 = done_cnt; r0 = req_log.size();
        enable = 1'b1; cycles(80); enable = 1'b0; cycles(2);
        chk("mask_led", LED, 4'b1011);
        chk("mask_nreq", req_log.size() - r0, 2);
        chk("mask_req0", req_log[r0], 0);
        chk("mask_req1", req_log[r0 + 1], 2);
        chk("mask_scan_done", done_cnt - d0, 1);
        chk("mask_no_timeout", timeout_err, 0);

        // Channel 1 never answers.
        ch_mask = 4'b1111; silent_ch = 1; adc_vals = '{10, 0, 300, 0};
        exp_q.push_back('{0, 10}); exp_q.push_back('{2, 300}); exp_q.push_back('{3, 0});
        d0 = done_cnt; r0 = req_log.size(); h0 = hold_log.size();
        enable = 1'b1; cycles(80); enable = 1'b0; cycles(2);
        chk("tmo_err", timeout_err, 1);
        chk("tmo_req_cycles", hold_log[h0 + 1], 9);
        chk("tmo_nreq", req_log.size() - r0, 4);
        chk("tmo_next_req", req_log[r0 + 2], 2);
        chk("tmo_led", LED, 4'b0110);
        chk("tmo_scan_done", done_cnt - d0, 1);
        chk("tmo_no_overrun", overrun_err, 0);

        // Enable drops while channel 1 is converting.
        silent_ch = -1; adc_lat = 6; adc_vals = '{500, 7, 0, 0};
        exp_q.push_back('{0, 500}); exp_q.push_back('{1, 7});
        d0 = done_cnt; r0 = req_log.size();
        enable = 1'b1;
        wait_req_ch(1);
        cycles(2);
        enable = 1'b0;
        cycles(30);
        chk("endis_nreq", req_log.size() - r0, 2);
        chk("endis_no_scan_done", done_cnt - d0, 0);
        chk("endis_led", LED, 4'b0101);
        chk("endis_queue_drained", exp_q.size(), 0);

        // Overrun: 20-cycle ADC, four channels.
        for (int i = 0; i < 4; i++) exp2_q.push_back('{i, 200 + i});
        chk("ovr_pre", ovr2, 0);
        en2 = 1'b1; cycles(145); en2 = 1'b0; cycles(5);
        chk("ovr_err", ovr2, 1);
        chk("ovr_nsamples", ns2, 4);
        chk("ovr_scan_done", done2_cnt, 1);
        chk("ovr_no_timeout", tmo2, 0);

        // Reset during WAIT, then a stray late conversion result.
        adc_lat = 6; ch_mask = 4'b1111;
        enable = 1'b1;
        wait_req_ch(0);
        cycles(2);
        reset = 1'b0;
        #1;
        chk("rstw_adc_req_async", adc_req, 0);
        enable = 1'b0;
        cycles(2);
        chk("rstw_led", LED, 0);
        chk("rstw_sticky_cleared", {timeout_err, overrun_err, ovr2}, 0);
        reset = 1'b1;
        cycles(1);
        inj_data = 12'hFFF;
        inj_cnt++;
        cycles(10);
        chk("rstw_led_after", LED, 0);
        chk("rstw_sample_data", sample_data, 0);
        chk("rstw_adc_req", adc_req, 0);
        chk("rstw_state_idle", u_dut.state == IDLE, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/sensor_scan_scheduler.md
SENSOR_SCAN_SCHEDULER -- requirements
Module: sensor_scan_scheduler

Interface
REQ-001 Parameters SHALL be:
- NUM_CH, default 4: sensor channels sharing the single ADC.
- DATA_W, default 12: ADC sample width.
- PERIOD, default 1000: clock cycles between scan starts.
- TIMEOUT, default 64: max cycles waiting for adc_valid.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-low.
- enable, in, 1: scanning allowed.
- ch_mask, in, NUM_CH: channel i scanned when bit i = 1.
- thresh, in, DATA_W: alarm threshold.
- adc_req, out, 1: conversion request, level.
- adc_ch, out, clog2(NUM_CH): channel under conversion.
- adc_valid, in, 1: conversion complete, 1-cycle pulse.
- adc_data, in, DATA_W: result, valid with adc_valid.
- sample_valid, out, 1: 1-cycle pulse, new sample published.
- sample_ch, out, clog2(NUM_CH): channel of the published sample.
- sample_data, out, DATA_W: published sample.
- LED, out, NUM_CH: per-channel alarm.
- scan_done, out, 1: 1-cycle pulse at scan end.
- timeout_err, out, 1: sticky.
- overrun_err, out, 1: sticky.

Function
REQ-003 Period timer SHALL count 0..PERIOD-1 while enable=1, emit tick at count PERIOD-1 and wrap to 0; it SHALL hold at 0 while enable=0.
REQ-004 FSM states SHALL be IDLE, SELECT, REQ, WAIT, STORE.
REQ-005 IDLE->SELECT on tick when enable=1 and ch_mask!=0; ch_mask SHALL be latched at that edge and channel pointer set to 0.
REQ-006 SELECT SHALL advance the pointer to the lowest latched-enabled channel >= pointer, then go to REQ; when none remains, it SHALL pulse scan_done and return to IDLE.
REQ-007 REQ SHALL assert adc_req with adc_ch = pointer and go to WAIT the next cycle.
REQ-008 adc_req and adc_ch SHALL stay stable throughout WAIT; adc_valid SHALL be ignored when adc_req=0.
REQ-009 In WAIT, adc_valid=1 SHALL capture adc_data, deassert adc_req and go to STORE.
REQ-010 In WAIT, TIMEOUT cycles without adc_valid SHALL deassert adc_req, set timeout_err, leave LED unchanged and go to SELECT with pointer+1.
REQ-011 STORE SHALL:
- pulse sample_valid with sample_ch and sample_data;
- set LED[ch]=1 if data > thresh (strict, unsigned), otherwise LED[ch]=0;
- go to SELECT with pointer+1.
REQ-012 Latency SHALL be exactly 1 cycle from the adc_valid edge to the sample_valid pulse.
REQ-013 A tick arriving outside IDLE SHALL set overrun_err, be dropped, and leave the running scan undisturbed.
REQ-014 enable falling mid-scan SHALL let the current conversion complete, or time out, and publish; the FSM SHALL then return to IDLE without scan_done.
REQ-015 LED bits of unscanned channels SHALL retain their value.
REQ-016 Pointer increment past NUM_CH-1 SHALL end the scan; no wrap within a scan.
REQ-017 thresh SHALL be sampled in the STORE cycle.

Reset
REQ-018 reset=0 SHALL asynchronously force:
- state IDLE, timer 0;
- adc_req, sample_valid and scan_done to 0;
- adc_ch, sample_ch, sample_data and LED to 0;
- timeout_err and overrun_err to 0.
REQ-019 Reset asserted mid-handshake SHALL drop adc_req immediately; the first adc_valid after release SHALL be ignored unless adc_req=1.
REQ-020 Sticky errors SHALL clear only on reset.

Structure
REQ-021 Package agri_soc_pkg SHALL hold the FSM state enum and the defaults NUM_CH_DEF and DATA_W_DEF.
REQ-022 The period timer SHALL be a sub-module named scan_tick_timer (PERIOD parameter; ports clk, reset, enable, tick).

Verification (PERIOD=50, TIMEOUT=8, NUM_CH=4)
REQ-023 Full scan: mask=4'b1111, thresh=100, ADC answers after 3 cycles with data 50,150,99,101 -> sample_ch 0..3 in order, LED=4'b1010, one scan_done.
REQ-024 Masking: mask=4'b0101 -> only channels 0 and 2 requested; LED[1] and LED[3] unchanged.
REQ-025 Timeout: channel 1 never answers -> adc_req drops after 8 WAIT cycles, timeout_err=1, channel 2 requested next, scan_done still pulses.
REQ-026 Overrun: ADC latency 20 cycles with 4 channels -> overrun_err=1; no scan restarts mid-scan.
REQ-027 Reset mid-WAIT, then a late adc_valid=1 with data 0xFFF -> no sample_valid, LED=0, state IDLE.
REQ-028 enable dropped during channel 1 WAIT -> channel 1 sample published, no channel 2 request, no scan_done.
